// File: rtl/overlay_pkg.sv
// Shared geometry, colour type and the seven-segment style digit font used by the
// BCD overlay and its font ROM.
package overlay_pkg;

   localparam int         GLYPH_W = 8;
   localparam int         GLYPH_H = 16;
   localparam logic [3:0] G_DASH  = 4'd10;

   typedef logic [11:0] rgb12_t;

   localparam rgb12_t FG_DEFAULT = 12'h001;
   localparam rgb12_t BG_DEFAULT = 12'hFFF;

   // Segment set {a,b,c,d,e,f,g}; glyphs 11..15 are blank.
   function automatic logic [6:0] seg_code(input logic [3:0] glyph);
      case (glyph)
         4'd0:    return 7'h7E;
         4'd1:    return 7'h30;
         4'd2:    return 7'h6D;
         4'd3:    return 7'h79;
         4'd4:    return 7'h33;
         4'd5:    return 7'h5B;
         4'd6:    return 7'h5F;
         4'd7:    return 7'h70;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h7B;
         4'd10:   return 7'h01;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [7:0] font_row(input logic [3:0] glyph, input logic [3:0] row);
      logic [6:0] s;
      logic [7:0] r;
      s = seg_code(glyph);
      r = 8'h00;
      if (row == 4'd1 || row == 4'd2)
         r = s[6] ? 8'h7E : 8'h00;
      else if (row >= 4'd3 && row <= 4'd6)
         r = (s[1] ? 8'h60 : 8'h00) | (s[5] ? 8'h06 : 8'h00);
      else if (row == 4'd7 || row == 4'd8)
         r = s[0] ? 8'h7E : 8'h00;
      else if (row >= 4'd9 && row <= 4'd12)
         r = (s[2] ? 8'h60 : 8'h00) | (s[4] ? 8'h06 : 8'h00);
      else if (row == 4'd13 || row == 4'd14)
         r = s[3] ? 8'h7E : 8'h00;
      return r;
   endfunction

endpackage

// File: rtl/digit_font_rom.sv
// 16 glyphs x 16 rows x 8 bits font ROM with registered read data.
module digit_font_rom
   import overlay_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] addr,
   output logic [7:0] data
);

   always_ff @(posedge clk) begin
      data <= font_row(addr[7:4], addr[3:0]);
   end

endmodule

// File: rtl/bcd_digit_overlay.sv
// Pipelined VGA overlay drawing a row of BCD digit cells from a per-frame shadow copy,
// with a frame-counted blinking edit cursor. Latency is 3 pixel clocks.
module bcd_digit_overlay
   import overlay_pkg::*;
#(
   parameter int     NUM_DIGITS   = 6,
   parameter int     X0           = 192,
   parameter int     Y0           = 64,
   parameter int     PITCH        = 28,
   parameter int     SCALE        = 1,
   parameter int     BLINK_FRAMES = 30,
   parameter rgb12_t FG           = FG_DEFAULT,
   parameter rgb12_t BG           = BG_DEFAULT
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    video_on,
   input  logic [9:0]              pixel_x,
   input  logic [9:0]              pixel_y,
   input  logic                    frame_start,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    edit_en,
   input  logic [3:0]              edit_sel,
   output rgb12_t                  rgb_o,
   output logic                    hit_o,
   output logic                    fb_o
);

   localparam int CELL_W = GLYPH_W << SCALE;
   localparam int CELL_H = GLYPH_H << SCALE;
   localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [4*NUM_DIGITS-1:0] shadow;
   logic [CNT_W-1:0]        cnt;
   logic                    phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
         cnt    <= '0;
         phase  <= 1'b0;
      end else if (frame_start) begin
         shadow <= digits_in;
         if (cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   int         px, py, cell_x;
   logic       hit_s0, hide_s0;
   logic [3:0] cell_s0, nib_s0, glyph_s0, row_s0;
   logic [2:0] col_s0;

   // Descending scan so the lowest-index matching cell is the one kept.
   always_comb begin
      px      = int'(pixel_x);
      py      = int'(pixel_y);
      hit_s0  = 1'b0;
      cell_s0 = '0;
      cell_x  = X0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (py >= Y0 && py < Y0 + CELL_H &&
             px >= X0 + i*PITCH && px < X0 + i*PITCH + CELL_W) begin
            hit_s0  = 1'b1;
            cell_s0 = 4'(i);
            cell_x  = X0 + i*PITCH;
         end
      end
      nib_s0   = shadow[4*int'(cell_s0) +: 4];
      glyph_s0 = (nib_s0 > 4'd9) ? G_DASH : nib_s0;
      row_s0   = 4'((py - Y0) >> SCALE);
      col_s0   = 3'((px - cell_x) >> SCALE);
      hide_s0  = edit_en && phase && hit_s0 && (edit_sel == cell_s0);
   end

   logic       vld_p1, hit_p1, hide_p1;
   logic [3:0] glyph_p1, row_p1;
   logic [2:0] col_p1;
   logic       vld_p2, hit_p2, hide_p2;
   logic [2:0] col_p2;
   logic [7:0] font_p2;
   logic       bit_p2;

   // Stage 1 -> 2: cell decode registered, ROM addressed; stage 2 -> 3: ROM data returns.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         hit_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         hit_p2 <= 1'b0;
      end else begin
         vld_p1 <= video_on;
         hit_p1 <= hit_s0;
         vld_p2 <= vld_p1;
         hit_p2 <= hit_p1;
      end
   end

   always_ff @(posedge clk) begin
      glyph_p1 <= glyph_s0;
      row_p1   <= row_s0;
      col_p1   <= col_s0;
      hide_p1  <= hide_s0;
      col_p2   <= col_p1;
      hide_p2  <= hide_p1;
   end

   digit_font_rom u_rom (
      .clk  (clk),
      .addr ({glyph_p1, row_p1}),
      .data (font_p2)
   );

   assign bit_p2 = font_p2[3'd7 - col_p2];

   // Stage 3: bit select and colour.
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_o <= '0;
         hit_o <= 1'b0;
         fb_o  <= 1'b0;
      end else begin
         rgb_o <= !vld_p2 ? 12'h000 : ((hit_p2 && bit_p2 && !hide_p2) ? FG : BG);
         hit_o <= hit_p2;
         fb_o  <= hit_p2 && bit_p2;
      end
   end

endmodule

// File: tb/tb_bcd_digit_overlay.sv
// Directed bench for bcd_digit_overlay: reset, static render, tearing, invalid BCD,
// blink timing and blanking latency against hand-written font rows.
module tb_bcd_digit_overlay;
   import overlay_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       video_on = 1'b0;
   logic       frame_start = 1'b0;
   logic       edit_en = 1'b0;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic [23:0] digits_in = '0;
   logic [3:0] edit_sel = '0;
   rgb12_t     rgb_o;
   logic       hit_o, fb_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bcd_digit_overlay #(.BLINK_FRAMES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .video_on    (video_on),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .frame_start (frame_start),
      .digits_in   (digits_in),
      .edit_en     (edit_en),
      .edit_sel    (edit_sel),
      .rgb_o       (rgb_o),
      .hit_o       (hit_o),
      .fb_o        (fb_o)
   );

   typedef struct {
      logic   chk;
      logic   chk_hit;
      rgb12_t rgb;
      logic   hit;
      logic   fb;
      int     x;
      int     y;
   } exp_t;

   exp_t q[$];

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   // Rows 0..15 of the reference glyphs, row 0 in the top byte.
   function automatic logic [7:0] font_ref(input int g, input int row);
      logic [127:0] t;
      case (g)
         0:       t = 128'h007E7E666666660000666666667E7E00;
         1:       t = 128'h00000006060606000006060606000000;
         7:       t = 128'h007E7E06060606000006060606000000;
         default: t = 128'h000000000000007E7E00000000000000;
      endcase
      return t[127 - 8*row -: 8];
   endfunction

   task automatic step(input int x, input int y, input logic v, input logic fs,
                       input logic chk, input logic chk_hit,
                       input rgb12_t er, input logic eh, input logic ef);
      exp_t e, o;
      @(negedge clk);
      rst         = 1'b0;
      pixel_x     = 10'(x);
      pixel_y     = 10'(y);
      video_on    = v;
      frame_start = fs;
      @(posedge clk);
      #1;
      e.chk = chk; e.chk_hit = chk_hit; e.rgb = er; e.hit = eh; e.fb = ef; e.x = x; e.y = y;
      q.push_back(e);
      if (q.size() == 3) begin
         o = q.pop_front();
         if (o.chk) begin
            check($sformatf("rgb(%0d,%0d)", o.x, o.y), rgb_o, o.rgb);
            if (o.chk_hit) begin
               check($sformatf("hit(%0d,%0d)", o.x, o.y), 12'(hit_o), 12'(o.hit));
               check($sformatf("fb(%0d,%0d)", o.x, o.y), 12'(fb_o), 12'(o.fb));
            end
         end
      end
   endtask

   task automatic idle(input logic fs);
      step(0, 0, 1'b1, fs, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
   endtask

   task automatic pix(input int x, input int y, input int cx, input int g, input logic hid);
      logic       in;
      logic [7:0] r;
      logic       b;
      in = x >= cx && x < cx + 16 && y >= 64 && y < 96;
      b  = 1'b0;
      if (in) begin
         r = font_ref(g, (y - 64) >> 1);
         b = r[7 - ((x - cx) >> 1)];
      end
      step(x, y, 1'b1, 1'b0, 1'b1, 1'b1, (b && !hid) ? 12'h001 : 12'hFFF, in, b);
   endtask

   task automatic blank(input int x, input int y);
      step(x, y, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
   endtask

   task automatic reset_cycle(input int x, input int y, input logic fs);
      @(negedge clk);
      rst         = 1'b1;
      pixel_x     = 10'(x);
      pixel_y     = 10'(y);
      video_on    = 1'b1;
      frame_start = fs;
      @(posedge clk);
      #1;
      check("rst_rgb", rgb_o, 12'h000);
      check("rst_hit", 12'(hit_o), 12'h000);
      check("rst_fb", 12'(fb_o), 12'h000);
      q.delete();
   endtask

   initial begin
      // Reset with a coincident frame_start that must be ignored.
      digits_in = 24'h250417;
      reset_cycle(194, 70, 1'b1);
      for (int i = 0; i < 3; i++) reset_cycle(194, 70, 1'b0);
      step(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
      pix(194, 70, 192, 0, 1'b0);
      idle(1'b0); idle(1'b0);

      // Static render of cell 0 with a mid-frame change that must not tear.
      idle(1'b1);
      for (int y = 64; y < 96; y++) begin
         if (y == 80) digits_in = 24'h250411;
         for (int x = 190; x < 210; x++) pix(x, y, 192, 7, 1'b0);
      end
      for (int y = 64; y < 96; y++)
         for (int x = 220; x < 236; x++) pix(x, y, 220, 1, 1'b0);
      idle(1'b0); idle(1'b0);

      // New value only after the next frame_start.
      idle(1'b1);
      for (int x = 192; x < 208; x++) begin
         pix(x, 66, 192, 1, 1'b0);
         pix(x, 70, 192, 1, 1'b0);
      end

      // Invalid BCD nibble in cell 2 renders the dash.
      digits_in = 24'h250C11;
      idle(1'b1);
      for (int y = 64; y < 96; y++)
         for (int x = 248; x < 264; x++) pix(x, y, 248, 10, 1'b0);

      // Blanking alternation pins latency at exactly 3; edges outside the cells.
      pix(250, 78, 248, 10, 1'b0);
      blank(250, 78);
      pix(250, 78, 248, 10, 1'b0);
      blank(250, 78);
      blank(250, 78);
      pix(250, 78, 248, 10, 1'b0);
      pix(191, 80, 192, 1, 1'b0);
      pix(208, 80, 192, 1, 1'b0);
      pix(194, 63, 192, 1, 1'b0);
      pix(194, 96, 192, 1, 1'b0);

      // Mid-frame reset, then blink over six frames.
      pix(250, 78, 248, 10, 1'b0);
      reset_cycle(250, 78, 1'b0);
      digits_in = 24'h250417;
      edit_en   = 1'b1;
      for (int f = 0; f < 6; f++) begin
         if (f > 0) idle(1'b1);
         edit_sel = 4'd3;
         pix(278, 66, 276, 0, (f == 2 || f == 3));
         edit_sel = 4'd9;
         pix(278, 66, 276, 0, 1'b0);
      end
      idle(1'b0); idle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
